// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch slice.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  localparam int          FIFO_DEPTH       = 2;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry {pc, instr} FIFO; entry 0 is always the head, entry 1 the tail.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DataWidth = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic                 pop,
  input  logic                 clear,
  input  logic [31:0]          push_pc,
  input  logic [DataWidth-1:0] push_data,
  output logic [1:0]           count,
  output logic [31:0]          head_pc,
  output logic [DataWidth-1:0] head_data
);

  logic [31:0]          pc0_q, pc0_d, pc1_q, pc1_d;
  logic [DataWidth-1:0] data0_q, data0_d, data1_q, data1_d;
  logic [1:0]           count_q, count_d;
  logic                 full;

  assign full = (count_q == 2'(FIFO_DEPTH));

  always_comb begin
    pc0_d   = pc0_q;
    pc1_d   = pc1_q;
    data0_d = data0_q;
    data1_d = data1_q;
    count_d = count_q;
    if (clear) begin
      count_d = 2'd0;
    end else begin
      case ({push && (pop || !full), pop})
        2'b10: begin
          if (count_q == 2'd0) begin
            pc0_d   = push_pc;
            data0_d = push_data;
          end else begin
            pc1_d   = push_pc;
            data1_d = push_data;
          end
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          pc0_d   = pc1_q;
          data0_d = data1_q;
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          // Occupancy is unchanged; the new entry lands behind whatever remains.
          if (count_q == 2'd1) begin
            pc0_d   = push_pc;
            data0_d = push_data;
          end else begin
            pc0_d   = pc1_q;
            data0_d = data1_q;
            pc1_d   = push_pc;
            data1_d = push_data;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc0_q   <= '0;
      pc1_q   <= '0;
      data0_q <= '0;
      data1_q <= '0;
      count_q <= '0;
    end else begin
      pc0_q   <= pc0_d;
      pc1_q   <= pc1_d;
      data0_q <= data0_d;
      data1_q <= data1_d;
      count_q <= count_d;
    end
  end

  assign count     = count_q;
  assign head_pc   = pc0_q;
  assign head_data = data0_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: sequential PC, one-cycle imem, 2-deep buffer, redirect flush.
// Optional redirect misalignment flag enabled by FETCH_MISALIGN_TRAP_EN.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int          Address   = 8,
  parameter int          DataWidth = 32,
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 redirect_en,
  input  logic [31:0]          redirect_pc,
  output logic                 imem_request,
  output logic                 imem_we_re,
  output logic [3:0]           imem_mask,
  output logic [Address-1:0]   imem_address,
  input  logic                 imem_valid,
  input  logic [DataWidth-1:0] imem_data,
  output logic                 instr_valid,
  input  logic                 instr_ready,
  output logic [DataWidth-1:0] instr,
  output logic [31:0]          instr_pc,
  output logic                 misaligned
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        inflight_q, inflight_d;
  logic        push, pop, clear;
  logic [1:0]  count;
  logic [2:0]  occ;

  assign pop  = instr_valid && instr_ready;
  assign occ  = {1'b0, count} + {2'b00, inflight_q} - {2'b00, pop};

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    imem_request = 1'b0;
    push         = 1'b0;
    clear        = 1'b0;
    case (state_q)
      ST_IDLE: state_d = ST_RUN;
      ST_RUN, ST_FLUSH: begin
        imem_request = !redirect_en && (occ < 3'd2);
        // Responses seen in FLUSH belong to the abandoned stream.
        push = (state_q == ST_RUN) && imem_valid && inflight_q && !redirect_en;
        if (redirect_en) begin
          clear   = 1'b1;
          pc_d    = {redirect_pc[31:2], 2'b00};
          state_d = inflight_q ? ST_FLUSH : ST_RUN;
        end else begin
          state_d = ST_RUN;
          if (imem_request) pc_d = pc_q + 32'd4;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    inflight_d = imem_request;
    req_pc_d   = imem_request ? pc_q : req_pc_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
    end
  end

  fetch_fifo #(.DataWidth(DataWidth)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .clear     (clear),
    .push_pc   (req_pc_q),
    .push_data (imem_data),
    .count     (count),
    .head_pc   (instr_pc),
    .head_data (instr)
  );

  assign instr_valid  = (count != 2'd0);
  assign imem_we_re   = 1'b0;
  assign imem_mask    = 4'b1111;
  assign imem_address = pc_q[Address+1:2];

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misaligned_q, misaligned_d;

  always_comb begin
    misaligned_d = misaligned_q;
    if (redirect_en) misaligned_d = |redirect_pc[1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) misaligned_q <= 1'b0;
    else      misaligned_q <= misaligned_d;
  end

  assign misaligned = misaligned_q;
`else
  logic unused_low_bits;
  assign unused_low_bits = ^redirect_pc[1:0];
  assign misaligned      = 1'b0;
`endif

endmodule
